// File: rtl/conv_pkg.sv
// Shared definitions for the convolver and its downstream max-pool stage.
package conv_pkg;

   localparam int CONV_WIDTH = 8;
   localparam int CONV_LENX  = 7;
   localparam int CONV_LENF  = 3;
   // Convolver output frame length ("valid" convolution).
   localparam int CONV_LEN   = CONV_LENX - CONV_LENF + 1;

   typedef logic signed [CONV_WIDTH-1:0] sample_t;

   // Number of pooled outputs per frame, including a short final window.
   function automatic int pool_outs(input int len, input int pool);
      return (len + pool - 1) / pool;
   endfunction

endpackage

// File: rtl/conv_maxpool_if.sv
// Stream bundle for the max-pool stage: y input stream and z pooled output.
interface conv_maxpool_if #(parameter int WIDTH = 8);

   logic signed [WIDTH-1:0] s_data_in_y;
   logic                    s_valid_y;
   logic                    s_ready_y;
   logic signed [WIDTH-1:0] m_data_out_z;
   logic                    m_valid_z;
   logic                    m_ready_z;
   logic                    m_last_z;

   // Environment side: feeds y, consumes z.
   modport master (
      output s_data_in_y, s_valid_y, m_ready_z,
      input  s_ready_y, m_data_out_z, m_valid_z, m_last_z
   );

   // Stage side.
   modport slave (
      input  s_data_in_y, s_valid_y, m_ready_z,
      output s_ready_y, m_data_out_z, m_valid_z, m_last_z
   );

endinterface

// File: rtl/conv_maxpool_pool_out_reg.sv
// One-entry valid/ready output register: load, drain, hold stable while stalled.
module pool_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic signed [WIDTH-1:0] load_data,
   input  logic                    load_last,
   input  logic                    ready,
   output logic                    valid,
   output logic signed [WIDTH-1:0] data,
   output logic                    last,
   output logic                    full_stall
);

   // Full and not draining: a new load must wait.
   assign full_stall = valid && !ready;

   // Load wins over drain so a simultaneous drain+load leaves no bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_maxpool.sv
// Streaming non-overlapping max-pool over frames of LEN signed samples.
module conv_maxpool
   import conv_pkg::*;
#(
   parameter int WIDTH  = CONV_WIDTH,
   parameter int LEN    = CONV_LEN,
   parameter int POOL   = 2,
   parameter int LOGLEN = 3
) (
   input  logic clk,
   input  logic reset,
   conv_maxpool_if.slave bus
);

   localparam int WCW = (POOL > 1) ? $clog2(POOL) : 1;

   logic [WCW-1:0]          win_cnt;
   logic [LOGLEN-1:0]       frm_cnt;
   logic signed [WIDTH-1:0] max_r;
   logic signed [WIDTH-1:0] cand;
   logic                    win_end;
   logic                    frm_end;
   logic                    closing;
   logic                    accept;
   logic                    stall;

   assign win_end = (win_cnt == WCW'(POOL - 1));
   assign frm_end = (frm_cnt == LOGLEN'(LEN - 1));
   assign closing = win_end || frm_end;

   // Only a closing sample needs the output register; others never stall.
   assign bus.s_ready_y = !(closing && stall);
   assign accept        = bus.s_valid_y && bus.s_ready_y;

   // First sample of a window seeds the max; later ones take a signed max.
   always_comb begin
      cand = bus.s_data_in_y;
      if (win_cnt != '0 && max_r > bus.s_data_in_y)
         cand = max_r;
   end

   // Window/frame counters and running max advance on each accepted sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_cnt <= '0;
         frm_cnt <= '0;
         max_r   <= '0;
      end else if (accept) begin
         if (closing) begin
            win_cnt <= '0;
            frm_cnt <= frm_end ? '0 : frm_cnt + LOGLEN'(1);
         end else begin
            max_r   <= cand;
            win_cnt <= win_cnt + WCW'(1);
            frm_cnt <= frm_cnt + LOGLEN'(1);
         end
      end
   end

   pool_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk        (clk),
      .reset      (reset),
      .load       (accept && closing),
      .load_data  (cand),
      .load_last  (frm_end),
      .ready      (bus.m_ready_z),
      .valid      (bus.m_valid_z),
      .data       (bus.m_data_out_z),
      .last       (bus.m_last_z),
      .full_stall (stall)
   );

endmodule

// File: doc/conv_maxpool.md
# conv_maxpool

Streaming max-pool stage directly downstream of the generated convolution top. It consumes the ReLU-clamped `y` stream one sample per handshake and emits the maximum of each non-overlapping window of `POOL` samples on a registered valid/ready output. Frames are `LEN` samples long, where `LEN` equals the convolver's `LENX-LENF+1`. A short final window is flushed at frame end, and its output carries `m_last_z`.

## Interface
- `WIDTH`, 8, sample width, signed two's complement; must match the convolver's `WIDTH`
- `LEN`, 5, samples per input frame (≥1)
- `POOL`, 2, window size (≥1; `POOL=1` is a registered pass-through)
- `LOGLEN`, 3, counter width, ≥ clog2(`LEN`+1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `s_data_in_y`  in  `WIDTH`  signed input sample
- `s_valid_y`  in  1  input sample valid
- `s_ready_y`  out  1  stage can accept a sample
- `m_data_out_z`  out  `WIDTH`  signed pooled sample
- `m_valid_z`  out  1  pooled sample valid
- `m_ready_z`  in  1  downstream accepts
- `m_last_z`  out  1  qualifies `m_data_out_z` as the last pooled sample of the frame

## Operation
- Transfer rules: input accepted when `s_valid_y && s_ready_y`; output consumed when `m_valid_z && m_ready_z`.
- State registers:
  - `win_cnt` counts 0..`POOL`-1.
  - `frm_cnt` counts 0..`LEN`-1.
  - `max_r` holds the running window max.
  - Output register holds `m_data_out_z`, `m_last_z` and `m_valid_z`.
- `closing` (combinational) = `win_cnt==POOL-1 || frm_cnt==LEN-1`.
- On an accepted sample, `cand` = sample if `win_cnt==0`, otherwise max(`max_r`, sample) using a signed compare.
- Accepted sample, not closing: `max_r` ← `cand`; `win_cnt`++; `frm_cnt`++.
- Accepted sample, closing:
  - Output register ← `cand`, with `m_last_z` = (`frm_cnt==LEN-1`) and `m_valid_z` ← 1.
  - `win_cnt` ← 0.
  - `frm_cnt` ← `frm_cnt==LEN-1` ? 0 : `frm_cnt`+1.
- `s_ready_y` = !(`closing` && `m_valid_z` && !`m_ready_z`).
  - Non-closing samples are never stalled.
  - A closing sample stalls only while the output register is full and not draining.
- Output drain:
  - Output consumed and no closing sample accepted in the same cycle: `m_valid_z` ← 0.
  - Simultaneous drain and load: the new value is loaded and `m_valid_z` stays 1, with no bubble.
- Output stability: `m_data_out_z` and `m_last_z` hold stable while `m_valid_z && !m_ready_z`.
- Partial windows:
  - When `LEN` mod `POOL` ≠ 0, the final window has `LEN mod POOL` samples.
  - Output count per frame is ceil(`LEN`/`POOL`).
- No arithmetic widening: only compare and select, so no saturation is needed.

## Timing
- Reset values (asserted low, asynchronous): `m_valid_z`=0, `m_data_out_z`=0, `m_last_z`=0, `win_cnt`=0, `frm_cnt`=0, `max_r`=0.
  - `s_ready_y` is therefore 1 from reset.
- Reset mid-window: the partial window is discarded, and the next accepted sample starts a new frame.
- Latency: 1 cycle from acceptance of a closing sample to `m_valid_z`=1.
- Throughput: one input per cycle sustained when `m_ready_z`=1.
- Combinational paths: `s_ready_y` depends combinationally on `m_ready_z`. There is no path from `s_valid_y` to `s_ready_y`.
- Frame boundary: back-to-back frames need no idle cycle. The first sample of frame n+1 may be accepted in the cycle after the closing sample of frame n.

## Structure
- Package `conv_pkg` is shared with the convolver top. It holds:
  - the sample type `logic signed [WIDTH-1:0]`
  - the `LEN` derivation (`LENX-LENF+1`)
  - a function returning ceil(`LEN`/`POOL`) for benches
- Sub-module `pool_out_reg`: one-entry valid/ready output register with load, drain and hold-stable behaviour. It is reusable for other stream stages.
- The counter and compare datapath stay in `conv_maxpool`.

## Test plan
1. `LEN`=5, `POOL`=2, input 3,7,2,9,4 with `m_ready_z`=1 → outputs 7, 9, 4. `m_last_z`=1 only on 4. Each output appears 1 cycle after its closing sample.
2. Hold `m_ready_z`=0 while output 7 is pending and feed 2,9 → 2 is accepted and 9 stalls (`s_ready_y`=0). Raise `m_ready_z` → 7 drains, 9 loads in the same cycle, and `m_valid_z` stays high.
3. Negative values -3,-8 (`POOL`=2) → output -3. Input -128,127 → output 127 (signed compare).
4. Two consecutive frames of 1..5 with no gap → outputs 2,4,5,2,4,5. `m_last_z` is set on each 5, and `frm_cnt` wraps cleanly.
5. Assert `reset` low after the first sample of a window, then send 6,1,... → the discarded sample does not affect the result, and the first output is 6.
6. `POOL`=1, `LEN`=4, random stream with random `m_ready_z` → the output equals the input sequence delayed, with no drops or duplicates. `m_last_z` is set every 4th output.
